// File: rtl/mips_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
//
// Purpose : Groups the signals between the multicycle MIPS control unit and
//           its datapath into one bundle.
//
// Signals : op, funct    instruction fields from the instruction register
//           zero         ALU zero flag
//           pcen         PC register enable
//           memwrite     memory write enable
//           irwrite      instruction register enable
//           regwrite     register file write enable
//           iord         memory address select (0 PC, 1 ALUOut)
//           memtoreg     write-data select (0 ALUOut, 1 Data register)
//           regdst       write-register select (0 rt, 1 rd)
//           alusrca      ALU A select (0 PC, 1 A register)
//           alusrcb      ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//           pcsrc        next-PC select (00 ALU, 01 ALUOut, 10 jump)
//           alucontrol   ALU function code
//           illegal      unsupported opcode seen in DECODE
//           state        current FSM state (debug)
//
// Modports: master - the control unit (drives all control outputs)
//           slave  - the datapath (drives op/funct/zero)
// ----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op,
        input  funct,
        input  zero,
        output pcen,
        output memwrite,
        output irwrite,
        output regwrite,
        output iord,
        output memtoreg,
        output regdst,
        output alusrca,
        output alusrcb,
        output pcsrc,
        output alucontrol,
        output illegal,
        output state
    );

    modport slave (
        output op,
        output funct,
        output zero,
        input  pcen,
        input  memwrite,
        input  irwrite,
        input  regwrite,
        input  iord,
        input  memtoreg,
        input  regdst,
        input  alusrca,
        input  alusrcb,
        input  pcsrc,
        input  alucontrol,
        input  illegal,
        input  state
    );

endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Purpose : Control unit for the multicycle MIPS datapath. A Moore main FSM
//           sequences fetch/decode/execute/memory/writeback over several
//           cycles per instruction. Also holds the ALU decoder (aluop + funct
//           to a 3-bit ALU function) and the PC-enable logic.
//
// Ports   : clk    rising-edge clock
//           reset  synchronous, active-high reset
//           bus    mips_multicycle_ctrl_if.master (op/funct/zero in, all
//                  mux selects, write enables, alucontrol, illegal, state out)
//
// Config  : MIPS_BNE_EN - when defined, bne (op 000101) is supported through
//                         state BNEEX (12). When undefined, bne is illegal.
//
// Notes   : Outputs decode from state only, except alucontrol (state+funct),
//           pcen (state+zero) and illegal (state+op). While reset is high all
//           write enables and illegal are forced low so an interrupted
//           instruction cannot commit anything in the reset cycle.
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl (
    input  logic                        clk,
    input  logic                        reset,
    mips_multicycle_ctrl_if.master      bus
);

    // ------------------------------------------------------------------------
    // Opcodes and function codes
    // ------------------------------------------------------------------------
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
`ifdef MIPS_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnSlt   = 6'b101010;

    localparam logic [2:0] AluAnd  = 3'b000;
    localparam logic [2:0] AluOr   = 3'b001;
    localparam logic [2:0] AluAdd  = 3'b010;
    localparam logic [2:0] AluSub  = 3'b110;
    localparam logic [2:0] AluSlt  = 3'b111;

    // ------------------------------------------------------------------------
    // FSM state encoding (4 bits; 13-15 never reached)
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StBneEx   = 4'd12
    } state_e;

    state_e     r_state;
    state_e     w_next_state;

    // Raw (pre-reset-gating) Moore outputs
    logic       w_pcwrite;
    logic       w_branch;
`ifdef MIPS_BNE_EN
    logic       w_branchne;
`endif
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_iord;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [1:0] w_aluop;
    logic       w_illegal;
    logic [2:0] w_alucontrol;
    logic       w_pc_take;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = StFetch;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
`ifdef MIPS_BNE_EN
        w_branchne   = 1'b0;
`endif
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_iord       = 1'b0;
        w_memtoreg   = 1'b0;
        w_regdst     = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_pcsrc      = 2'b00;
        w_aluop      = 2'b00;
        w_illegal    = 1'b0;

        case (r_state)
            StFetch: begin
                // PC + 4 computed and written while the instruction is latched
                w_alusrcb    = 2'b01;
                w_irwrite    = 1'b1;
                w_pcwrite    = 1'b1;
                w_next_state = StDecode;
            end
            StDecode: begin
                // Precompute branch target PC + (imm << 2) into ALUOut
                w_alusrcb = 2'b11;
                case (bus.op)
                    OpLw, OpSw: w_next_state = StMemAdr;
                    OpRtype:    w_next_state = StExecute;
                    OpBeq:      w_next_state = StBranch;
                    OpAddi:     w_next_state = StAddiEx;
                    OpJ:        w_next_state = StJump;
`ifdef MIPS_BNE_EN
                    OpBne:      w_next_state = StBneEx;
`endif
                    default: begin
                        w_illegal    = 1'b1;
                        w_next_state = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                // Only lw and sw reach here, so anything but sw is a load
                w_next_state = (bus.op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                w_iord       = 1'b1;
                w_next_state = StMemWb;
            end
            StMemWb: begin
                w_memtoreg   = 1'b1;
                w_regwrite   = 1'b1;
                w_next_state = StFetch;
            end
            StMemWr: begin
                w_iord       = 1'b1;
                w_memwrite   = 1'b1;
                w_next_state = StFetch;
            end
            StExecute: begin
                w_alusrca    = 1'b1;
                w_aluop      = 2'b10;
                w_next_state = StAluWb;
            end
            StAluWb: begin
                w_regdst     = 1'b1;
                w_regwrite   = 1'b1;
                w_next_state = StFetch;
            end
            StBranch: begin
                w_alusrca    = 1'b1;
                w_aluop      = 2'b01;
                w_pcsrc      = 2'b01;
                w_branch     = 1'b1;
                w_next_state = StFetch;
            end
            StAddiEx: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_next_state = StAddiWb;
            end
            StAddiWb: begin
                w_regwrite   = 1'b1;
                w_next_state = StFetch;
            end
            StJump: begin
                w_pcsrc      = 2'b10;
                w_pcwrite    = 1'b1;
                w_next_state = StFetch;
            end
`ifdef MIPS_BNE_EN
            StBneEx: begin
                w_alusrca    = 1'b1;
                w_aluop      = 2'b01;
                w_pcsrc      = 2'b01;
                w_branchne   = 1'b1;
                w_next_state = StFetch;
            end
`endif
            default: begin
                // Unreachable encodings: all outputs low, recover to FETCH
                w_next_state = StFetch;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------------
    always_comb begin
        w_alucontrol = AluAdd;
        case (w_aluop)
            2'b00: w_alucontrol = AluAdd;
            2'b01: w_alucontrol = AluSub;
            2'b10: begin
                case (bus.funct)
                    FnAdd:   w_alucontrol = AluAdd;
                    FnSub:   w_alucontrol = AluSub;
                    FnAnd:   w_alucontrol = AluAnd;
                    FnOr:    w_alucontrol = AluOr;
                    FnSlt:   w_alucontrol = AluSlt;
                    default: w_alucontrol = AluAdd;
                endcase
            end
            default: w_alucontrol = AluAdd;
        endcase
    end

    // ------------------------------------------------------------------------
    // PC enable
    // ------------------------------------------------------------------------
`ifdef MIPS_BNE_EN
    assign w_pc_take = w_pcwrite | (w_branch & bus.zero) | (w_branchne & ~bus.zero);
`else
    assign w_pc_take = w_pcwrite | (w_branch & bus.zero);
`endif

    // ------------------------------------------------------------------------
    // Outputs; anything that commits state is suppressed during reset
    // ------------------------------------------------------------------------
    assign bus.pcen       = w_pc_take  & ~reset;
    assign bus.memwrite   = w_memwrite & ~reset;
    assign bus.irwrite    = w_irwrite  & ~reset;
    assign bus.regwrite   = w_regwrite & ~reset;
    assign bus.illegal    = w_illegal  & ~reset;
    assign bus.iord       = w_iord;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.regdst     = w_regdst;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.alucontrol = w_alucontrol;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed bench for mips_multicycle_ctrl. The stimulus process drives
// op/funct/zero/reset one cycle at a time and pushes that cycle's expected
// output bundle into a queue; the monitor pops one entry per cycle on the
// falling edge and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic clk;
    logic reset;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [19:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    // {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
    //  alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], illegal, state[3:0]}
    function automatic logic [19:0] act_vec();
        return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord,
                bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
                bus.alucontrol, bus.illegal, bus.state};
    endfunction

    // Monitor: one expected entry per cycle, checked mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [19:0] a;
            e = exp_q.pop_front();
            a = act_vec();
            n_vec++;
            if (a !== e.v) begin
                n_bad++;
                $display("FAIL %s: got pcen=%b mw=%b irw=%b rw=%b iord=%b m2r=%b rdst=%b asa=%b asb=%b pcs=%b aluc=%b ill=%b st=%0d, want %b_%b_%b_%b_%b_%b_%b_%b_%b_%b_%b_%b_%0d",
                         e.name, a[19], a[18], a[17], a[16], a[15], a[14], a[13], a[12],
                         a[11:10], a[9:8], a[7:5], a[4], a[3:0],
                         e.v[19], e.v[18], e.v[17], e.v[16], e.v[15], e.v[14], e.v[13],
                         e.v[12], e.v[11:10], e.v[9:8], e.v[7:5], e.v[4], e.v[3:0]);
            end
        end
    end

    // Push the expected bundle for the current cycle, then advance one clock
    task automatic chk(input string nm, input logic [3:0] st,
                       input logic pcen, input logic memw, input logic irw,
                       input logic regw, input logic iord, input logic m2r,
                       input logic rdst, input logic asa, input logic [1:0] asb,
                       input logic [1:0] pcs, input logic [2:0] aluc,
                       input logic ill);
        exp_t e;
        e.name = nm;
        e.v = {pcen, memw, irw, regw, iord, m2r, rdst, asa, asb, pcs, aluc, ill, st};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic z);
        bus.op    = o;
        bus.funct = f;
        bus.zero  = z;
    endtask

    task automatic fetch_c(input string nm);
        chk(nm, 4'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    endtask

    task automatic decode_c(input string nm, input logic ill);
        chk(nm, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, ill);
    endtask

    // R-type through EXECUTE into ALUWB, checking the decoded ALU function
    task automatic rtype(input string nm, input logic [5:0] f, input logic [2:0] aluc);
        set_in(6'b000000, f, 1'b0);
        fetch_c({nm, "_fetch"});
        decode_c({nm, "_decode"}, 0);
        chk({nm, "_exec"}, 4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, aluc, 0);
        chk({nm, "_aluwb"}, 4'd7, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        set_in(6'b100011, 6'b000000, 1'b0);
        @(posedge clk);
        #1;
        // Reset state: FETCH selects but no write enables
        chk("reset_state", 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
        reset = 1'b0;

        // lw: 0,1,2,3,4
        fetch_c("lw_fetch");
        decode_c("lw_decode", 0);
        chk("lw_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
        chk("lw_memrd", 4'd3, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        chk("lw_memwb", 4'd4, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);

        // sw: 0,1,2,5
        set_in(6'b101011, 6'b000000, 1'b0);
        fetch_c("sw_fetch");
        decode_c("sw_decode", 0);
        chk("sw_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
        chk("sw_memwr", 4'd5, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);

        // R-type ALU function decode
        rtype("slt", 6'b101010, 3'b111);
        rtype("sub", 6'b100010, 3'b110);
        rtype("or",  6'b100101, 3'b001);
        rtype("and", 6'b100100, 3'b000);
        rtype("fnx", 6'b000111, 3'b010);

        // beq taken / not taken
        set_in(6'b000100, 6'b000000, 1'b1);
        fetch_c("beqt_fetch");
        decode_c("beqt_decode", 0);
        chk("beqt_branch", 4'd8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
        set_in(6'b000100, 6'b000000, 1'b0);
        fetch_c("beqn_fetch");
        decode_c("beqn_decode", 0);
        chk("beqn_branch", 4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);

        // addi: 0,1,9,10
        set_in(6'b001000, 6'b000000, 1'b0);
        fetch_c("addi_fetch");
        decode_c("addi_decode", 0);
        chk("addi_ex", 4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
        chk("addi_wb", 4'd10, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);

        // j: 0,1,11
        set_in(6'b000010, 6'b000000, 1'b0);
        fetch_c("j_fetch");
        decode_c("j_decode", 0);
        chk("j_jump", 4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0);

        // Unsupported opcode
        set_in(6'b111111, 6'b000000, 1'b0);
        fetch_c("ill_fetch");
        decode_c("ill_decode", 1);

        // bne, both zero polarities
`ifdef MIPS_BNE_EN
        set_in(6'b000101, 6'b000000, 1'b0);
        fetch_c("bnet_fetch");
        decode_c("bnet_decode", 0);
        chk("bnet_ex", 4'd12, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
        set_in(6'b000101, 6'b000000, 1'b1);
        fetch_c("bnen_fetch");
        decode_c("bnen_decode", 0);
        chk("bnen_ex", 4'd12, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
`else
        set_in(6'b000101, 6'b000000, 1'b0);
        fetch_c("bne_fetch");
        decode_c("bne_decode", 1);
`endif

        // Reset held two cycles starting mid-EXECUTE
        set_in(6'b000000, 6'b100000, 1'b1);
        fetch_c("rx_fetch");
        decode_c("rx_decode", 0);
        reset = 1'b1;
        chk("rx_exec_rst", 4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
        chk("rx_fetch_rst", 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
        reset = 1'b0;
        fetch_c("rx_release");

        // Reset during ALUWB must suppress the register write
        decode_c("rw_decode", 0);
        chk("rw_exec", 4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
        reset = 1'b1;
        chk("rw_aluwb_rst", 4'd7, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
        reset = 1'b0;
        fetch_c("rw_release");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control unit for the multicycle MIPS datapath: a Moore main FSM that sequences the shared ALU, register file, instruction/data memory port and PC register over several cycles per instruction. It also contains the ALU decoder (aluop/funct to 3-bit ALU function) and the PC-enable logic. It sits beside the datapath, takes op/funct from the instruction register and the ALU zero flag, and drives every mux select and write enable.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable (we3)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  write-data select: 0 = ALUOut, 1 = Data register
- regdst  out  1  write-register select: 0 = rt, 1 = rd
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B select: 00 = B register, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU function: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- illegal  out  1  unsupported opcode seen in DECODE
- state  out  4  current FSM state (debug/verification)

## Operation
- State register: 4 bits, synchronous reset to FETCH (0). Outputs are decoded from state only, except alucontrol (state + funct), pcen (state + zero) and illegal (state + op).
- States and asserted outputs (all unlisted outputs 0):
  - FETCH(0): alusrcb=01, irwrite, pcwrite -> DECODE
  - DECODE(1): alusrcb=11 -> by op: lw 100011/sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; any other -> FETCH with illegal=1
  - MEMADR(2): alusrca=1, alusrcb=10 -> MEMRD if lw, MEMWR if sw
  - MEMRD(3): iord=1 -> MEMWB
  - MEMWB(4): memtoreg=1, regwrite -> FETCH
  - MEMWR(5): iord=1, memwrite -> FETCH
  - EXECUTE(6): alusrca=1, aluop=10 -> ALUWB
  - ALUWB(7): regdst=1, regwrite -> FETCH
  - BRANCH(8): alusrca=1, aluop=01, pcsrc=01, branch -> FETCH
  - ADDIEX(9): alusrca=1, alusrcb=10 -> ADDIWB
  - ADDIWB(10): regwrite -> FETCH
  - JUMP(11): pcsrc=10, pcwrite -> FETCH
  - Encodings 12-15 (13-15 with BNE enabled) unreachable; if entered -> FETCH next cycle, all outputs 0.
- aluop (internal): 00 -> alucontrol 010; 01 -> 110; 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010; 11 -> 010.
- pcen = pcwrite | (branch & zero).

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- alucontrol, pcen, illegal are combinational; they are valid the same cycle as their inputs.
- While reset=1: state forced to FETCH at the next edge; pcen, memwrite, irwrite, regwrite and illegal forced 0 combinationally, so reset mid-instruction produces no write in that cycle. First cycle after reset deasserts is FETCH with full FETCH outputs.
- No stalls or handshakes; memory is single-cycle.

## Configuration
- MIPS_BNE_EN defined: opcode 000101 in DECODE -> BNEEX(12): alusrca=1, aluop=01, pcsrc=01, branchne; pcen additionally ORs (branchne & ~zero); bne takes 3 cycles.
- Undefined: 000101 treated as illegal (illegal=1 in DECODE, -> FETCH); state 12 unreachable.

## Test plan
- Reset held 2 cycles mid-EXECUTE -> no regwrite/pcen during reset; state=0 with irwrite=pcwrite=pcen=1 on first cycle after release.
- lw (op 100011) -> state sequence 0,1,2,3,4,0; iord=1 in state 3; memtoreg=1, regwrite=1 in 4.
- R-type slt (funct 101010) -> state 6 with alucontrol=111, then 7 with regdst=1, regwrite=1.
- beq with zero=1 in state 8 -> pcen=1, pcsrc=01, alucontrol=110; repeat with zero=0 -> pcen=0; both return to state 0 next cycle.
- op 111111 -> illegal=1 in state 1, then state 0; no memwrite/regwrite asserted.
- op 000101: with MIPS_BNE_EN, zero=0 -> state 12, pcen=1; zero=1 -> pcen=0; without macro -> illegal=1, state 1 -> 0.
